// File: rtl/ay_bus_master.sv
// Host-side initiator for the AY-3-8913 PSG parallel bus (BDIR/BC1/DA).
// Turns valid/ready register requests into latch-address / write / read bus sequences.
module ay_bus_master #(
    parameter int HOLD_CYCLES    = 2,
    parameter int GAP_CYCLES     = 1,
    parameter bit SKIP_SAME_ADDR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [3:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       bdir,
    output logic       bc1,
    output logic [7:0] bus_out,
    output logic [7:0] bus_oe,
    input  logic [7:0] bus_in
);

    localparam int MAX_CYCLES = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_AGAP,
        ST_XFER,
        ST_XGAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          write_q, write_d;
    logic [3:0]    addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [3:0]    last_addr_q, last_addr_d;
    logic          last_vld_q, last_vld_d;
    logic [7:0]    rdata_q, rdata_d;

    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_rdata_q, rsp_rdata_d;
    logic          bdir_q, bdir_d;
    logic          bc1_q, bc1_d;
    logic [7:0]    bus_out_q, bus_out_d;
    logic          bus_oe_q, bus_oe_d;

    logic          hold_done;
    logic          gap_done;
    logic          same_addr;

    assign hold_done = (cnt_q == HOLD_LAST);
    assign gap_done  = (cnt_q == GAP_LAST);
    assign same_addr = SKIP_SAME_ADDR && last_vld_q && (req_addr == last_addr_q);

    // Next-state, datapath capture and the values the bus pins take next cycle.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        last_addr_d = last_addr_q;
        last_vld_d  = last_vld_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = same_addr ? ST_XFER : ST_ADDR;
                end
            end
            ST_ADDR: begin
                last_addr_d = addr_q;
                last_vld_d  = 1'b1;
                if (hold_done) begin
                    state_d = (GAP_CYCLES > 0) ? ST_AGAP : ST_XFER;
                end
            end
            ST_AGAP: begin
                if (gap_done) begin
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (hold_done) begin
                    if (!write_q) begin
                        rdata_d = bus_in;
                    end
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_XGAP;
                    end else begin
                        state_d = ST_IDLE;
                        if (!write_q) begin
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = bus_in;
                        end
                    end
                end
            end
            ST_XGAP: begin
                if (gap_done) begin
                    state_d = ST_IDLE;
                    if (!write_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = rdata_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counter restarts on every state entry and never runs past terminal count.
        if (state_d != state_q || state_q == ST_IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Pin values are derived from the upcoming state so the pins themselves are flops.
        bdir_d    = 1'b0;
        bc1_d     = 1'b0;
        bus_out_d = 8'h00;
        bus_oe_d  = 1'b0;
        case (state_d)
            ST_ADDR: begin
                bdir_d    = 1'b1;
                bc1_d     = 1'b1;
                bus_out_d = {4'h0, addr_d};
                bus_oe_d  = 1'b1;
            end
            ST_AGAP: begin
                bus_out_d = {4'h0, addr_d};
                bus_oe_d  = 1'b1;
            end
            ST_XFER: begin
                if (write_d) begin
                    bdir_d    = 1'b1;
                    bus_out_d = wdata_d;
                    bus_oe_d  = 1'b1;
                end else begin
                    bc1_d     = 1'b1;
                end
            end
            ST_XGAP: begin
                if (write_d) begin
                    bus_out_d = wdata_d;
                    bus_oe_d  = 1'b1;
                end
            end
            default: begin
                bdir_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            // NOTE: the block holds only a handful of registers, so all of them are reset, not just control.
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            write_q     <= 1'b0;
            addr_q      <= 4'h0;
            wdata_q     <= 8'h00;
            last_addr_q <= 4'h0;
            last_vld_q  <= 1'b0;
            rdata_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            bdir_q      <= 1'b0;
            bc1_q       <= 1'b0;
            bus_out_q   <= 8'h00;
            bus_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            last_addr_q <= last_addr_d;
            last_vld_q  <= last_vld_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            bdir_q      <= bdir_d;
            bc1_q       <= bc1_d;
            bus_out_q   <= bus_out_d;
            bus_oe_q    <= bus_oe_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bdir      = bdir_q;
    assign bc1       = bc1_q;
    assign bus_out   = bus_out_q;
    assign bus_oe    = {8{bus_oe_q}};

endmodule

// File: tb/tb_ay_bus_master.sv
// Self-checking bench for ay_bus_master: three parameterisations, directed table,
// reset/back-to-back sequences and randomized traffic against a trace-level model.
module tb_ay_bus_master;

    localparam int HP [3] = '{2, 1, 2};
    localparam int GP [3] = '{1, 0, 1};
    localparam bit SP [3] = '{1'b1, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid [3];
    logic       req_ready [3];
    logic       req_write [3];
    logic [3:0] req_addr  [3];
    logic [7:0] req_wdata [3];
    logic       rsp_valid [3];
    logic [7:0] rsp_rdata [3];
    logic       busy      [3];
    logic       bdir      [3];
    logic       bc1       [3];
    logic [7:0] bus_out   [3];
    logic [7:0] bus_oe    [3];
    logic [7:0] bus_in    [3];

    always #5 clk = ~clk;

    ay_bus_master #(.HOLD_CYCLES(2), .GAP_CYCLES(1), .SKIP_SAME_ADDR(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .bdir(bdir[0]), .bc1(bc1[0]), .bus_out(bus_out[0]), .bus_oe(bus_oe[0]), .bus_in(bus_in[0])
    );

    ay_bus_master #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .SKIP_SAME_ADDR(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .bdir(bdir[1]), .bc1(bc1[1]), .bus_out(bus_out[1]), .bus_oe(bus_oe[1]), .bus_in(bus_in[1])
    );

    ay_bus_master #(.HOLD_CYCLES(2), .GAP_CYCLES(1), .SKIP_SAME_ADDR(1'b0)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .busy(busy[2]),
        .bdir(bdir[2]), .bc1(bc1[2]), .bus_out(bus_out[2]), .bus_oe(bus_oe[2]), .bus_in(bus_in[2])
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: last latched address per instance and last read data.
    bit         m_vld   [3];
    logic [3:0] m_last  [3];
    logic [7:0] m_rdata [3];

    typedef struct {
        logic bd;
        logic bc;
        logic oe;
        logic [7:0] out;
        bit   cap;
    } cyc_t;

    typedef struct {
        int         k;
        bit         wr;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] din;
        int         exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic rdy, input logic bsy, input logic rv,
                                         input logic bd, input logic bc, input logic [7:0] oe,
                                         input logic [7:0] out, input logic [7:0] rd);
        return {3'b000, rdy, bsy, rv, bd, bc, oe, out, rd};
    endfunction

    function automatic logic [31:0] observe(input int k);
        return pack(req_ready[k], busy[k], rsp_valid[k], bdir[k], bc1[k], bus_oe[k], bus_out[k], rsp_rdata[k]);
    endfunction

    function automatic logic [31:0] idle_vec(input int k, input logic rv);
        return pack(1'b1, 1'b0, rv, 1'b0, 1'b0, 8'h00, 8'h00, m_rdata[k]);
    endfunction

    // One transaction, starting and ending at a negedge of an IDLE cycle.
    task automatic do_txn(input int k, input bit wr, input logic [3:0] a, input logic [7:0] d,
                          input logic [7:0] din, input string tag, output int busy_seen);
        cyc_t tr [$];
        cyc_t c;
        bit   skip;
        int   h;
        int   g;
        h = HP[k];
        g = GP[k];
        skip = SP[k] && m_vld[k] && (a == m_last[k]);
        if (!skip) begin
            for (int i = 0; i < h; i++) begin c = '{1'b1, 1'b1, 1'b1, {4'h0, a}, 1'b0}; tr.push_back(c); end
            for (int i = 0; i < g; i++) begin c = '{1'b0, 1'b0, 1'b1, {4'h0, a}, 1'b0}; tr.push_back(c); end
        end
        for (int i = 0; i < h; i++) begin
            if (wr) c = '{1'b1, 1'b0, 1'b1, d, 1'b0};
            else    c = '{1'b0, 1'b1, 1'b0, 8'h00, (i == h - 1)};
            tr.push_back(c);
        end
        for (int i = 0; i < g; i++) begin
            if (wr) c = '{1'b0, 1'b0, 1'b1, d, 1'b0};
            else    c = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
            tr.push_back(c);
        end

        busy_seen = 0;
        check({tag, "_ready_t0"}, {31'b0, req_ready[k]}, 32'd1);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = a;
        req_wdata[k] = d;
        @(posedge clk);
        @(negedge clk);
        req_valid[k] = 1'b0;
        req_write[k] = 1'($urandom);
        req_addr[k]  = 4'($urandom);
        req_wdata[k] = 8'($urandom);
        for (int i = 0; i < tr.size(); i++) begin
            bus_in[k] = tr[i].cap ? din : ~din;
            check($sformatf("%s_k%0d_c%0d", tag, k, i + 1), observe(k),
                  pack(1'b0, 1'b1, 1'b0, tr[i].bd, tr[i].bc, {8{tr[i].oe}}, tr[i].out, m_rdata[k]));
            busy_seen += int'(busy[k]);
            @(negedge clk);
        end
        if (!skip) begin
            m_last[k] = a;
            m_vld[k]  = 1'b1;
        end
        if (!wr) m_rdata[k] = din;
        check($sformatf("%s_k%0d_idle", tag, k), observe(k), idle_vec(k, !wr));
        busy_seen += int'(busy[k]);
    endtask

    task automatic idle_cycles(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("idle_k%0d", k), observe(k), idle_vec(k, 1'b0));
        end
    endtask

    vec_t tbl [$];
    int   bs;

    initial begin
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = 4'h0;
            req_wdata[k] = 8'h00; bus_in[k] = 8'h00;
            m_vld[k] = 1'b0; m_last[k] = 4'h0; m_rdata[k] = 8'h00;
        end

        tbl.push_back('{0, 1'b1, 4'd7, 8'h38, 8'h00, 6});
        tbl.push_back('{0, 1'b1, 4'd8, 8'h0F, 8'h00, 6});
        tbl.push_back('{0, 1'b1, 4'd8, 8'h1F, 8'h00, 3});
        tbl.push_back('{0, 1'b0, 4'd2, 8'h00, 8'hA5, 6});
        tbl.push_back('{0, 1'b0, 4'd2, 8'h00, 8'h5A, 3});
        tbl.push_back('{0, 1'b1, 4'd2, 8'hC3, 8'h00, 3});
        tbl.push_back('{1, 1'b1, 4'd1, 8'hFF, 8'h00, 2});
        tbl.push_back('{1, 1'b1, 4'd1, 8'hEE, 8'h00, 1});
        tbl.push_back('{1, 1'b0, 4'd4, 8'h00, 8'h3C, 2});
        tbl.push_back('{2, 1'b1, 4'd8, 8'h1F, 8'h00, 6});
        tbl.push_back('{2, 1'b1, 4'd8, 8'h1F, 8'h00, 6});

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) check($sformatf("reset_k%0d", k), observe(k), idle_vec(k, 1'b0));
        rst = 1'b0;
        @(negedge clk);

        // Reset in the second ADDR cycle of a write.
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 4'd7; req_wdata[0] = 8'h38;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("rst_mid_addr_phase", {30'b0, bdir[0], bc1[0]}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_addr_after", observe(0), idle_vec(0, 1'b0));
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin m_vld[k] = 1'b0; m_rdata[k] = 8'h00; end

        foreach (tbl[i]) begin
            do_txn(tbl[i].k, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].din, $sformatf("tbl%0d", i), bs);
            check($sformatf("tbl%0d_busy_len", i), bs, tbl[i].exp_busy);
            idle_cycles(tbl[i].k, 1);
        end

        // Back-to-back writes with req_valid held high.
        begin
            logic [7:0] phases [$];
            int   sent;
            int   viol;
            bit   prev10;
            bit   cur10;
            sent = 0; viol = 0; prev10 = 1'b0;
            for (int c = 0; c < 60; c++) begin
                if (req_ready[0] && busy[0]) viol++;
                cur10 = bdir[0] && !bc1[0];
                if (cur10 && !prev10) phases.push_back(bus_out[0]);
                prev10 = cur10;
                if (req_ready[0]) begin
                    if (sent < 3) begin
                        req_valid[0] = 1'b1; req_write[0] = 1'b1;
                        req_addr[0] = 4'(sent); req_wdata[0] = 8'hA0 + 8'(sent);
                        sent++;
                    end else begin
                        req_valid[0] = 1'b0;
                    end
                end
                @(negedge clk);
            end
            check("b2b_ready_while_busy", viol, 0);
            check("b2b_write_phases", phases.size(), 3);
            for (int i = 0; i < 3; i++)
                check($sformatf("b2b_data%0d", i), (i < phases.size()) ? {24'b0, phases[i]} : 32'hFFFF_FFFF,
                      {24'b0, 8'hA0 + 8'(i)});
            m_last[0] = 4'd2;
            m_vld[0]  = 1'b1;
        end

        // Randomized traffic on every parameterisation.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 40; n++) begin
                do_txn(k, 1'($urandom), 4'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), "rnd", bs);
                idle_cycles(k, $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ay_bus_master.md
Name: ay_bus_master

Overview:
- Host-side initiator for the AY-3-8913 PSG parallel bus: the far end of the BDIR/BC1/DA[7:0] interface that the PSG core samples.
- Accepts register read/write requests over a valid/ready port.
- Generates the latch-address → write/read bus sequence with programmable hold and gap timing.
- Used in the test harness and in a future on-chip sequencer that drives the PSG without an external CPU.

Parameters:
- HOLD_CYCLES, 2: cycles each active bus phase (latch, write, read) is held; legal ≥1.
- GAP_CYCLES, 1: inactive (BDIR=0, BC1=0) cycles after each active phase; legal ≥0 (0 = gap state skipped).
- SKIP_SAME_ADDR, 1: when 1, the address-latch phase is omitted if the request address equals the last latched address.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid & req_ready
- req_write  input  1  1 = register write, 0 = register read
- req_addr  input  4  PSG register index 0..15
- req_wdata  input  8  write data
- rsp_valid  output  1  one-cycle pulse: read data available
- rsp_rdata  output  8  read data, valid with rsp_valid
- busy  output  1  high whenever state ≠ IDLE
- bdir  output  1  PSG BDIR
- bc1  output  1  PSG BC1
- bus_out  output  8  DA bus drive value
- bus_oe  output  8  DA bus output enable, all bits equal, 1 = drive
- bus_in  input  8  DA bus sampled value

Behaviour:
- Bus encoding {bdir,bc1}: 00 inactive, 01 read, 10 write, 11 latch address.
- Reset (rst=1 at a clock edge), takes effect regardless of state, mid-transaction included:
  - state=IDLE; bdir=0, bc1=0, bus_out=0, bus_oe=0, rsp_valid=0, rsp_rdata=0, busy=0.
  - Latched-address-valid flag cleared; internal counter cleared.
  - req_ready=1 in the first cycle after reset is released.
- req_ready=1 only in IDLE; no request is accepted in any other state.
- On acceptance, req_write/req_addr/req_wdata are captured into internal registers. Later input changes are ignored.
- States, with the cycle counter reloaded on every state entry:
  - IDLE: bus 00, bus_oe=0. On accept → ADDR, or → XFER if SKIP_SAME_ADDR=1, the address-valid flag is set, and req_addr equals the last latched address.
  - ADDR: bus 11, bus_out={4'b0,addr}, bus_oe=1, for HOLD_CYCLES cycles. Last latched address := addr, flag set. → AGAP, or → XFER if GAP_CYCLES=0.
  - AGAP: bus 00, bus_out holds the address, bus_oe=1, for GAP_CYCLES cycles → XFER.
  - XFER, write: bus 10, bus_out=wdata, bus_oe=1.
  - XFER, read: bus 01, bus_oe=0, bus_out=0; bus_in is captured on the final XFER cycle.
  - XFER lasts HOLD_CYCLES cycles in both cases → XGAP, or → IDLE if GAP_CYCLES=0.
  - XGAP: bus 00, for GAP_CYCLES cycles → IDLE. A write keeps bus_out=wdata with bus_oe=1 (data hold); a read keeps bus_oe=0.
- rsp_valid pulses for exactly one cycle: the first IDLE cycle after a read. rsp_rdata is updated in that same cycle and held until the next read completes.
- Writes produce no response.
- All bus outputs are registered; no combinational path from req_* to bus pins.
- Write latency, request accepted in cycle T0 with full sequence:
  - busy=1 for 2·HOLD_CYCLES + 2·GAP_CYCLES cycles.
  - req_ready returns to 1 at T0 + 2·HOLD_CYCLES + 2·GAP_CYCLES + 1.
- With the address latch skipped, subtract HOLD_CYCLES + GAP_CYCLES.
- Back-to-back requests: a request held valid is accepted in the first IDLE cycle. The gap between transactions is bus-inactive for GAP_CYCLES plus one IDLE cycle.
- Counter width: $clog2(max(HOLD_CYCLES, GAP_CYCLES) + 1). The counter wraps nowhere; each state terminates exactly at terminal count.

Test Plan:
1. Reset mid-ADDR (defaults):
   - Stimulus: write addr=7, wdata=0x38 accepted; rst asserted in the 2nd ADDR cycle.
   - Required: next cycle bdir=bc1=0, bus_oe=0, busy=0, req_ready=1.
   - Required: a following write to addr 7 performs a full ADDR phase (flag cleared).
2. Write timing (defaults):
   - Stimulus: write addr=8, wdata=0x0F accepted at T0.
   - Required: {bdir,bc1}=11 with bus_out=0x08 at T1–T2; 00 at T3; 10 with bus_out=0x0F at T4–T5; 00 with bus_oe=1 at T6.
   - Required: req_ready=1 at T7; no rsp_valid.
3. Address skip:
   - Stimulus: after test 2, write addr=8, wdata=0x1F.
   - Required: no 11 phase; 10 at T1–T2, 00 at T3; req_ready=1 at T4.
   - With SKIP_SAME_ADDR=0: full 7-cycle sequence.
4. Read:
   - Stimulus: read addr=2 with bus_in=0xA5 driven during XFER.
   - Required: 01 for 2 cycles with bus_oe=0; rsp_valid=1 for exactly one cycle with rsp_rdata=0xA5 in the first IDLE cycle.
5. GAP_CYCLES=0, HOLD_CYCLES=1:
   - Stimulus: write addr=1, wdata=0xFF.
   - Required: 11 at T1, 10 at T2, 00 at T3; req_ready=1 at T3.
6. Back-to-back:
   - Stimulus: req_valid held high with three writes to addrs 0, 1, 2.
   - Required: each accepted only in IDLE; req_ready is never high while busy=1; exactly three 10 phases appear, carrying the correct data in order.
